// File: rtl/dpram_rw_pipe.sv
// Simple dual-port RAM: one byte-enabled write port, one pipelined read port
// with a valid strobe and a selectable same-address read/write policy.
module dpram_rw_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_DEPTH     = 256,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = 0,
  localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH,
  localparam int ADDR_W        = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_BYTES-1:0]  wr_be
);

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("dpram_rw_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_DEPTH < 2) begin : g_bad_depth
    $error("dpram_rw_pipe: DATA_DEPTH must be >= 2");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("dpram_rw_pipe: RD_LATENCY must be in 1..4");
  end
  if (COLLISION_MODE != 0 && COLLISION_MODE != 1) begin : g_bad_mode
    $error("dpram_rw_pipe: COLLISION_MODE must be 0 or 1");
  end

  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  collide;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [RD_LATENCY-1:0] vld;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_CMP;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_CMP;
  assign collide     = rd_en && wr_en && wr_in_range && (rd_addr == wr_addr);

  // Byte-lane write into the array; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Stage-1 read word: old contents, or the forwarded merged word on a
  // write-first collision; out-of-range reads return zero.
  always_comb begin
    old_word    = rd_in_range ? mem[rd_addr] : '0;
    merged_word = old_word;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (wr_be[k]) begin
        merged_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    rd_word = old_word;
    if (COLLISION_MODE == 1 && collide) begin
      rd_word = merged_word;
    end
  end

  // Valid shift register: one bit per stage, cleared by reset so in-flight
  // reads are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= rd_en;
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  assign rd_valid = vld[RD_LATENCY-1];

  if (RD_LATENCY == 1) begin : g_lat1
    // Single stage: the synchronous read register is the output register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data <= '0;
      end else if (rd_en) begin
        rd_data <= rd_word;
      end
    end
  end else begin : g_latn
    // Stage 1 is an enabled, unreset read register so the array maps to
    // block RAM; middle stages shift freely and the output register only
    // loads when a valid word arrives, giving hold-on-idle behaviour.
    logic [DATA_WIDTH-1:0] pipe [RD_LATENCY-1];

    // Synchronous read capture.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        pipe[0] <= rd_word;
      end
    end

    // Unconditional shift through the intermediate stages.
    always_ff @(posedge clk) begin
      for (int unsigned k = 1; k < RD_LATENCY - 1; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end

    // Output register: updates only for a valid word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data <= '0;
      end else if (vld[RD_LATENCY-2]) begin
        rd_data <= pipe[RD_LATENCY-2];
      end
    end
  end

endmodule

// File: tb/tb_dpram_rw_pipe.sv
// Directed testbench: two instances (read-first/latency 3/depth 256 and
// write-first/latency 4/depth 200) driven by shared stimulus, each checked
// against its own behavioural memory model and expected-read queue.
module tb_dpram_rw_pipe;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  exp_t        q [2][$];
  logic [31:0] last [2];
  logic [31:0] model [2][256];
  int          depth [2];
  int          lat [2];
  int          mode [2];

  dpram_rw_pipe #(
    .DATA_WIDTH(32), .DATA_DEPTH(256), .BYTE_WIDTH(8),
    .RD_LATENCY(3), .COLLISION_MODE(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  dpram_rw_pipe #(
    .DATA_WIDTH(32), .DATA_DEPTH(200), .BYTE_WIDTH(8),
    .RD_LATENCY(4), .COLLISION_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] dat);
    logic ev;
    ev = (q[d].size() > 0) && (q[d][0].due == cyc);
    chk(d == 0 ? "valid_a" : "valid_b", {31'b0, v}, {31'b0, ev});
    if (ev) begin
      chk(d == 0 ? "data_a" : "data_b", dat, q[d][0].data);
      last[d] = q[d][0].data;
      void'(q[d].pop_front());
    end else begin
      chk(d == 0 ? "hold_a" : "hold_b", dat, last[d]);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rd_valid_a, rd_data_a);
      mon(1, rd_valid_b, rd_data_b);
    end
  end

  task automatic step(input logic re, input logic [7:0] ra, input logic we,
                      input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [31:0] old, mrg;
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    for (int d = 0; d < 2; d++) begin
      old = (int'(ra) < depth[d]) ? model[d][ra] : 32'h0;
      mrg = old;
      for (int k = 0; k < 4; k++) if (be[k]) mrg[8*k +: 8] = wd[8*k +: 8];
      if (re) begin
        e.data = (mode[d] == 1 && we && ra == wa && int'(ra) < depth[d]) ? mrg : old;
        e.due  = cyc + lat[d];
        q[d].push_back(e);
      end
      if (we && int'(wa) < depth[d]) begin
        for (int k = 0; k < 4; k++) if (be[k]) model[d][wa][8*k +: 8] = wd[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 32'h0, 4'h0);
  endtask

  initial begin
    depth[0] = 256; lat[0] = 3; mode[0] = 0;
    depth[1] = 200; lat[1] = 4; mode[1] = 1;
    last[0] = '0;   last[1] = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_data_a", rd_data_a, 32'h0);
    chk("rst_valid_a", {31'b0, rd_valid_a}, 32'h0);
    chk("rst_data_b", rd_data_b, 32'h0);
    chk("rst_valid_b", {31'b0, rd_valid_b}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte enables: expect 0x11BB33DD
    step(1'b0, 8'd0, 1'b1, 8'd5, 32'h11223344, 4'b1111);
    step(1'b0, 8'd0, 1'b1, 8'd5, 32'hAABBCCDD, 4'b0101);
    chk("be_model", model[0][5], 32'h11BB33DD);
    step(1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0);

    // Preload 0..7, then back-to-back reads
    for (int a = 0; a < 8; a++) step(1'b0, 8'd0, 1'b1, 8'(a), 32'(a) * 32'h01010101, 4'hF);
    for (int a = 0; a < 8; a++) step(1'b1, 8'(a), 1'b0, 8'd0, 32'h0, 4'h0);
    idle(5);

    // wr_be = 0 is a no-op
    step(1'b0, 8'd0, 1'b1, 8'd6, 32'h99999999, 4'h0);
    step(1'b1, 8'd6, 1'b0, 8'd0, 32'h0, 4'h0);

    // Same-address collision, follow-up read, then differing-address pair
    step(1'b0, 8'd0, 1'b1, 8'd128, 32'hFFFFFFFF, 4'hF);
    step(1'b1, 8'd128, 1'b1, 8'd128, 32'h5A5A5A5A, 4'b0011);
    step(1'b1, 8'd128, 1'b0, 8'd0, 32'h0, 4'h0);
    step(1'b1, 8'd128, 1'b1, 8'd129, 32'h01020304, 4'hF);
    step(1'b1, 8'd129, 1'b0, 8'd0, 32'h0, 4'h0);
    idle(5);

    // Depth boundary (instance b has 200 words)
    step(1'b0, 8'd0, 1'b1, 8'd210, 32'h12345678, 4'hF);
    step(1'b0, 8'd0, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF);
    step(1'b1, 8'd210, 1'b0, 8'd0, 32'h0, 4'h0);
    step(1'b1, 8'd199, 1'b0, 8'd0, 32'h0, 4'h0);
    idle(5);

    // Hold: read addr 0 then sweep rd_addr with rd_en low
    step(1'b0, 8'd0, 1'b1, 8'd0, 32'hDEADBEEF, 4'hF);
    step(1'b1, 8'd0, 1'b0, 8'd0, 32'h0, 4'h0);
    for (int a = 0; a < 256; a++) step(1'b0, 8'(a), 1'b0, 8'd0, 32'h0, 4'h0);
    chk("hold_final_a", rd_data_a, 32'hDEADBEEF);
    chk("hold_final_b", rd_data_b, 32'hDEADBEEF);

    // Reset with two reads in flight
    step(1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0);
    step(1'b1, 8'd6, 1'b0, 8'd0, 32'h0, 4'h0);
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_data_a", rd_data_a, 32'h0);
    chk("midrst_valid_a", {31'b0, rd_valid_a}, 32'h0);
    chk("midrst_data_b", rd_data_b, 32'h0);
    chk("midrst_valid_b", {31'b0, rd_valid_b}, 32'h0);
    q[0].delete(); q[1].delete();
    last[0] = '0;  last[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);

    // Contents survive reset
    step(1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0);
    step(1'b1, 8'd199, 1'b0, 8'd0, 32'h0, 4'h0);
    idle(6);

    chk("drain_a", 32'(q[0].size()), 32'h0);
    chk("drain_b", 32'(q[1].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_rw_pipe.md
Name: dpram_rw_pipe

Overview:
Simple dual-port RAM (one write port, one read port) on a single clock. It has byte-enabled writes, a configurable read pipeline latency with a valid strobe, and a selectable read/write collision policy. It is the generalised successor to the basic dpram_rw. It serves as the storage core for FIFOs, line buffers and register-file style blocks that need more than 8-bit, single-latency, read-first storage.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
DATA_DEPTH, 256, number of words; must be >= 2; need not be a power of two
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
RD_LATENCY, 1, cycles from rd_en sample to rd_valid/rd_data; legal range 1..4
COLLISION_MODE, 0, 0 = read-first (old data on same-address read/write), 1 = write-first (new data forwarded)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_en  in  1  read request, sampled at posedge
rd_addr  in  $clog2(DATA_DEPTH)  read address
rd_data  out  DATA_WIDTH  read data, registered
rd_valid  out  1  one-cycle strobe: rd_data holds the result of the read issued RD_LATENCY cycles earlier
wr_en  in  1  write request, sampled at posedge
wr_addr  in  $clog2(DATA_DEPTH)  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  NUM_BYTES  per-lane byte enables; lane k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH]

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - rd_data = 0, rd_valid = 0.
  - All internal pipeline valid bits cleared.
  - Memory array is NOT reset; contents survive reset.
- Write:
  - On posedge with wr_en=1 and wr_addr < DATA_DEPTH, each lane k with wr_be[k]=1 is updated; other lanes keep their value.
  - wr_be = 0 is a no-op.
  - wr_addr >= DATA_DEPTH: write ignored.
- Read:
  - On posedge with rd_en=1, stage 1 captures mem[rd_addr] (or 0 if rd_addr >= DATA_DEPTH) plus a valid bit.
  - Stages 2..RD_LATENCY shift unconditionally every cycle; there is no stall/backpressure.
  - rd_valid is asserted exactly RD_LATENCY cycles after the sampling edge, for one cycle per read.
  - Back-to-back reads give back-to-back valids: full throughput of one read per cycle.
- Hold:
  - rd_data changes only when a valid word reaches the output stage; otherwise it holds its last value.
  - Example: after rd_en drops, changing rd_addr has no effect on rd_data.
- Collision (rd_en, wr_en, rd_addr == wr_addr, same edge):
  - COLLISION_MODE=0: stage 1 captures pre-write contents.
  - COLLISION_MODE=1: stage 1 captures the merged word (enabled lanes from wr_data, disabled lanes from old contents).
  - Differing addresses: no interaction.
- Read of a word whose write is one cycle earlier always returns the new data in both modes, since the write is already committed.
- Reset mid-operation: in-flight reads are dropped and no rd_valid is emitted for them. A write on the same edge as reset assertion is not guaranteed.
- Implementation: read stage 1 must be a synchronous read so the array infers block RAM. Later stages are plain flops. Parameter checks are done by elaboration-time assertion.

Test Plan:
- Byte enables: write 0x11223344 to addr 5 with wr_be=4'b1111, then 0xAABBCCDD with wr_be=4'b0101; read addr 5 -> 0x11BB33DD.
- Latency/throughput: RD_LATENCY=3, preload addrs 0..7 with value = addr*0x01010101, read 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles starting 3 cycles after the first rd_en, data in order.
- Collision: preload addr 128 = 0xFFFFFFFF, then same-cycle write 0x5A5A5A5A (wr_be=4'b0011) and read addr 128. COLLISION_MODE=0 -> 0xFFFFFFFF; COLLISION_MODE=1 -> 0xFFFF5A5A. A follow-up read returns 0xFFFF5A5A in both modes.
- Hold: read addr 0 (=0xDEADBEEF), then deassert rd_en and sweep rd_addr 0..255 -> rd_data stays 0xDEADBEEF, rd_valid stays 0.
- Reset mid-flight: RD_LATENCY=4, issue 2 reads, assert rst after 2 cycles -> rd_data=0 and rd_valid=0 immediately; no valid after release; previously written data still readable.
- Non-power-of-two: DATA_DEPTH=200, write addr 210 -> ignored. Read addr 210 -> 0 with rd_valid; addr 199 reads back correctly.
